// File: rtl/gecis_pkg.sv
// Shared state encodings and constants for the access-gate controller.
package gecis_pkg;

  typedef enum logic [2:0] {
    BOS   = 3'd0,
    SORGU = 3'd1,
    BEKLE = 3'd2,
    ACIK  = 3'd3,
    RED   = 3'd4,
    KILIT = 3'd5
  } durum_t;

  localparam int BEKLE_SINIR = 4;
  localparam int GECIS_W     = 8;

endpackage

// File: rtl/gecis_kontrol_sure_sayaci.sv
// Loadable down-counter; sifir_o flags that the loaded duration has elapsed.
module sure_sayaci #(
  parameter int W = 16
) (
  input  logic         saat,
  input  logic         reset,
  input  logic         yukle_i,
  input  logic [W-1:0] deger_i,
  output logic         sifir_o
);

  logic [W-1:0] sayac_q, sayac_d;

  always_comb begin
    sayac_d = sayac_q;
    if (yukle_i) begin
      sayac_d = deger_i;
    end else if (sayac_q != '0) begin
      sayac_d = sayac_q - W'(1);
    end
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) sayac_q <= '0;
    else       sayac_q <= sayac_d;
  end

  assign sifir_o = (sayac_q == '0);

endmodule

// File: rtl/gecis_kontrol.sv
// Access-gate controller: card -> checker query -> open gate, alarm or timed lockout.
// GECIS_SAYAC_EN enables the saturating pass counter; otherwise gecis_sayisi is 0.
module gecis_kontrol
  import gecis_pkg::*;
#(
  parameter int BIT        = 6,
  parameter int ACIK_SURE  = 8,
  parameter int KILIT_SURE = 16,
  parameter int HATA_LIMIT = 3
) (
  input  logic               saat,
  input  logic               reset,
  input  logic               kart_gecerli,
  input  logic [BIT-1:0]     kart_no,
  input  logic               kart_uyruk,
  output logic               hazir,
  output logic               basla,
  output logic [BIT-1:0]     kimlik_no,
  output logic               uyruk,
  input  logic               gecerli,
  input  logic               bitti,
  output logic               kapi_ac,
  output logic               alarm,
  output logic               kilitli,
  output logic [GECIS_W-1:0] gecis_sayisi
);

  localparam int SURE_MAX0 = (ACIK_SURE > KILIT_SURE) ? ACIK_SURE : KILIT_SURE;
  localparam int SURE_MAX  = (SURE_MAX0 > BEKLE_SINIR) ? SURE_MAX0 : BEKLE_SINIR;
  localparam int SW        = $clog2(SURE_MAX + 1);
  localparam int HW        = $clog2(HATA_LIMIT + 1);

  durum_t         durum_q, durum_d;
  logic [HW-1:0]  hata_q, hata_d, hata_art;
  logic [BIT-1:0] kimlik_q, kimlik_d;
  logic           uyruk_q, uyruk_d;
  logic           sure_yukle, sure_sifir, red_et;
  logic [SW-1:0]  sure_deger;

  assign hata_art = hata_q + HW'(1);

  // Each timed state loads the shared counter with (duration-1) on entry.
  always_comb begin
    durum_d    = durum_q;
    hata_d     = hata_q;
    kimlik_d   = kimlik_q;
    uyruk_d    = uyruk_q;
    sure_yukle = 1'b0;
    sure_deger = '0;
    red_et     = 1'b0;
    case (durum_q)
      BOS: begin
        if (kart_gecerli) begin
          kimlik_d = kart_no;
          uyruk_d  = kart_uyruk;
          durum_d  = SORGU;
        end
      end
      SORGU: begin
        durum_d    = BEKLE;
        sure_yukle = 1'b1;
        sure_deger = SW'(BEKLE_SINIR - 1);
      end
      BEKLE: begin
        if (bitti) begin
          if (gecerli) begin
            durum_d    = ACIK;
            hata_d     = '0;
            sure_yukle = 1'b1;
            sure_deger = SW'(ACIK_SURE - 1);
          end else begin
            red_et = 1'b1;
          end
        end else if (sure_sifir) begin
          red_et = 1'b1;
        end
      end
      ACIK:    if (sure_sifir) durum_d = BOS;
      RED:     durum_d = BOS;
      KILIT:   if (sure_sifir) durum_d = BOS;
      default: durum_d = BOS;
    endcase

    if (red_et) begin
      if (hata_art == HW'(HATA_LIMIT)) begin
        durum_d    = KILIT;
        hata_d     = '0;
        sure_yukle = 1'b1;
        sure_deger = SW'(KILIT_SURE - 1);
      end else begin
        durum_d = RED;
        hata_d  = hata_art;
      end
    end
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      durum_q  <= BOS;
      hata_q   <= '0;
      kimlik_q <= '0;
      uyruk_q  <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      hata_q   <= hata_d;
      kimlik_q <= kimlik_d;
      uyruk_q  <= uyruk_d;
    end
  end

  sure_sayaci #(.W(SW)) u_sure (
    .saat    (saat),
    .reset   (reset),
    .yukle_i (sure_yukle),
    .deger_i (sure_deger),
    .sifir_o (sure_sifir)
  );

`ifdef GECIS_SAYAC_EN
  logic [GECIS_W-1:0] gecis_q;
  logic               gecti;

  assign gecti = (durum_q == BEKLE) & bitti & gecerli;

  always_ff @(posedge saat or posedge reset) begin
    if (reset)                       gecis_q <= '0;
    else if (gecti && gecis_q != '1) gecis_q <= gecis_q + GECIS_W'(1);
  end

  assign gecis_sayisi = gecis_q;
`else
  assign gecis_sayisi = '0;
`endif

  assign hazir     = (durum_q == BOS) & ~reset;
  assign basla     = (durum_q == SORGU);
  assign kapi_ac   = (durum_q == ACIK);
  assign alarm     = (durum_q == RED) | (durum_q == KILIT);
  assign kilitli   = (durum_q == KILIT);
  assign kimlik_no = kimlik_q;
  assign uyruk     = uyruk_q;

endmodule

// File: tb/tb_gecis_kontrol.sv
// Self-checking bench for gecis_kontrol: transaction-level timeline model with randomized cards and verdicts.
module tb_gecis_kontrol;

  localparam int BIT = 6;
  localparam int A   = 8;
  localparam int K   = 16;
  localparam int L   = 3;

  logic           saat = 1'b0;
  logic           reset = 1'b1;
  logic           kart_gecerli = 1'b0;
  logic [BIT-1:0] kart_no = '0;
  logic           kart_uyruk = 1'b0;
  logic           gecerli = 1'b0;
  logic           bitti = 1'b0;
  logic           hazir, basla, uyruk, kapi_ac, alarm, kilitli;
  logic [BIT-1:0] kimlik_no;
  logic [7:0]     gecis_sayisi;

  int checks = 0;
  int errors = 0;

  // Reference model state: consecutive rejections, passes, last latched card.
  int             m_rej = 0;
  int             m_pass = 0;
  logic [BIT-1:0] m_id = '0;
  logic           m_uyr = 1'b0;

  gecis_kontrol #(.BIT(BIT), .ACIK_SURE(A), .KILIT_SURE(K), .HATA_LIMIT(L)) dut (
    .saat         (saat),
    .reset        (reset),
    .kart_gecerli (kart_gecerli),
    .kart_no      (kart_no),
    .kart_uyruk   (kart_uyruk),
    .hazir        (hazir),
    .basla        (basla),
    .kimlik_no    (kimlik_no),
    .uyruk        (uyruk),
    .gecerli      (gecerli),
    .bitti        (bitti),
    .kapi_ac      (kapi_ac),
    .alarm        (alarm),
    .kilitli      (kilitli),
    .gecis_sayisi (gecis_sayisi)
  );

  always #5 saat = ~saat;

  function automatic logic [7:0] beklenen_gecis();
`ifdef GECIS_SAYAC_EN
    return 8'(m_pass);
`else
    return 8'd0;
`endif
  endfunction

  // d: checker answers d cycles after basla (1..4 inside the wait window, 5 too late, 0 never).
  task automatic islem(input logic [BIT-1:0] id, input logic uyr, input int d,
                       input logic verdict, input int kes);
    int D, son;
    bit yanit, gec, kilit;
    logic [BIT+5:0] g, b;
    yanit = (d >= 1 && d <= 4);
    D     = yanit ? 1 + d : 5;
    gec   = yanit && verdict;
    kilit = 0;
    if (gec) begin
      m_rej  = 0;
      m_pass = (m_pass < 255) ? m_pass + 1 : 255;
      son    = D + A + 1;
    end else begin
      m_rej++;
      if (m_rej == L) begin
        kilit = 1;
        m_rej = 0;
        son   = D + K + 1;
      end else begin
        son = D + 2;
      end
    end
    m_id  = id;
    m_uyr = uyr;
    kart_gecerli = 1'b1;
    kart_no      = id;
    kart_uyruk   = uyr;
    for (int t = 1; t <= son; t++) begin
      @(negedge saat);
      b = {t == son, t == 1, gec && t > D && t <= D + A,
           !gec && (kilit ? (t > D && t <= D + K) : (t == D + 1)),
           kilit && t > D && t <= D + K, uyr, id};
      g = {hazir, basla, kapi_ac, alarm, kilitli, uyruk, kimlik_no};
      checks++;
      if (g !== b) begin
        errors++;
        $display("FAIL timeline t=%0d d=%0d {hazir,basla,kapi,alarm,kilit,uyruk,id} got %h expected %h",
                 t, d, g, b);
      end
      if (kes == t) begin
        kart_gecerli = 1'b0;
        bitti        = 1'b0;
        return;
      end
      if (t == son) begin
        kart_gecerli = 1'b0;
        bitti        = 1'b0;
        gecerli      = 1'b0;
      end else begin
        kart_gecerli = 1'($urandom_range(0, 1));
        kart_no      = BIT'($urandom);
        kart_uyruk   = 1'($urandom_range(0, 1));
        bitti        = (d > 0 && t == 1 + d);
        gecerli      = (d > 0 && t == 1 + d) ? verdict : 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (gecis_sayisi !== beklenen_gecis()) begin
      errors++;
      $display("FAIL gecis_sayisi got %0d expected %0d", gecis_sayisi, beklenen_gecis());
    end
  endtask

  task automatic bosta(input int n);
    logic [BIT+5:0] g, b;
    for (int i = 0; i < n; i++) begin
      @(negedge saat);
      b = {1'b1, 4'b0000, m_uyr, m_id};
      g = {hazir, basla, kapi_ac, alarm, kilitli, uyruk, kimlik_no};
      checks++;
      if (g !== b) begin
        errors++;
        $display("FAIL idle got %h expected %h", g, b);
      end
    end
  endtask

  task automatic reset_kontrol(input string ad);
    logic [BIT+5:0] g;
    g = {hazir, basla, kapi_ac, alarm, kilitli, uyruk, kimlik_no};
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL %s outputs got %h expected 0", ad, g);
    end
    checks++;
    if (gecis_sayisi !== 8'd0) begin
      errors++;
      $display("FAIL %s gecis_sayisi got %0d expected 0", ad, gecis_sayisi);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge saat);
    reset_kontrol("reset");
    reset = 1'b0;
    m_rej = 0; m_pass = 0; m_id = '0; m_uyr = 1'b0;
    bosta(2);
  endtask

  task automatic test_valid_pass();
    bosta(6);
    islem(BIT'($urandom), 1'b1, 1, 1'b1, 0);
  endtask

  task automatic test_red_kilit();
    for (int i = 0; i < 3; i++) islem(BIT'($urandom), 1'b0, 1, 1'b0, 0);
    bosta(1);
  endtask

  task automatic test_gecis_sifirlar();
    islem(6'd1, 1'b0, 1, 1'b0, 0);
    islem(6'd2, 1'b1, 1, 1'b0, 0);
    islem(6'd3, 1'b1, 1, 1'b1, 0);
    for (int i = 0; i < 3; i++) islem(BIT'(i + 10), 1'b0, 1, 1'b0, 0);
  endtask

  task automatic test_zaman_asimi();
    islem(6'd20, 1'b0, 0, 1'b1, 0);
    islem(6'd21, 1'b1, 4, 1'b1, 0);
    islem(6'd22, 1'b0, 5, 1'b1, 0);
    islem(6'd23, 1'b1, 4, 1'b0, 0);
    bosta(2);
  endtask

  task automatic test_rastgele();
    for (int i = 0; i < 40; i++) begin
      islem(BIT'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), 0);
      bosta(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_acik();
    islem(6'd33, 1'b1, 1, 1'b1, 4);
    #2 reset = 1'b1;
    #1;
    reset_kontrol("mid_reset");
    m_rej = 0; m_pass = 0; m_id = '0; m_uyr = 1'b0;
    @(negedge saat);
    reset = 1'b0;
    bosta(2);
  endtask

  task automatic test_doyma();
    for (int i = 0; i < 260; i++) islem(BIT'($urandom), 1'b1, 1, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_valid_pass();
    test_red_kilit();
    test_gecis_sifirlar();
    test_zaman_asimi();
    test_rastgele();
    test_reset_acik();
    test_doyma();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
